// File: rtl/drm_port_arbiter.sv
// Dual-client arbiter in front of a simple dual-port RAM: independent round-robin
// arbitration for the write and read ports, pipelined read return with write-first forwarding.
module drm_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  c0_wr_req,
    input  logic [ADDR_WIDTH-1:0] c0_wr_addr,
    input  logic [DATA_WIDTH-1:0] c0_wr_data,
    output logic                  c0_wr_gnt,
    input  logic                  c1_wr_req,
    input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
    input  logic [DATA_WIDTH-1:0] c1_wr_data,
    output logic                  c1_wr_gnt,

    input  logic                  c0_rd_req,
    input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
    output logic                  c0_rd_gnt,
    output logic                  c0_rd_valid,
    output logic [DATA_WIDTH-1:0] c0_rd_data,
    input  logic                  c1_rd_req,
    input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
    output logic                  c1_rd_gnt,
    output logic                  c1_rd_valid,
    output logic [DATA_WIDTH-1:0] c1_rd_data,

    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int unsigned LAT = RAM_RD_LATENCY;

    // Round-robin pointers: 1 means client 1 was granted last, so client 0 wins next.
    logic                  r_wr_last;
    logic                  r_rd_last;

    logic                  w_c0_wr_gnt;
    logic                  w_c1_wr_gnt;
    logic                  w_wr_hs;
    logic                  w_c0_rd_gnt;
    logic                  w_c1_rd_gnt;
    logic                  w_rd_hs;

    logic                  r_ram_wr_en;
    logic [ADDR_WIDTH-1:0] r_ram_wr_addr;
    logic [DATA_WIDTH-1:0] r_ram_wr_data;
    logic [ADDR_WIDTH-1:0] r_ram_rd_addr;

    // Return pipeline: stage 0 is the cycle the address sits on the RAM, stage LAT is return.
    logic [LAT:0]          r_vld;
    logic [LAT:0]          r_id;
    logic [LAT:1]          r_coll;
    logic [DATA_WIDTH-1:0] r_fwd [1:LAT];

    logic                  w_coll;
    logic                  w_ret_vld;
    logic [DATA_WIDTH-1:0] w_ret_data;

    // Write-port grant
    always_comb begin
        w_c0_wr_gnt = 1'b0;
        w_c1_wr_gnt = 1'b0;
        if (!rst) begin
            if (c0_wr_req && (!c1_wr_req || r_wr_last)) begin
                w_c0_wr_gnt = 1'b1;
            end else if (c1_wr_req) begin
                w_c1_wr_gnt = 1'b1;
            end
        end
    end

    // Read-port grant
    always_comb begin
        w_c0_rd_gnt = 1'b0;
        w_c1_rd_gnt = 1'b0;
        if (!rst) begin
            if (c0_rd_req && (!c1_rd_req || r_rd_last)) begin
                w_c0_rd_gnt = 1'b1;
            end else if (c1_rd_req) begin
                w_c1_rd_gnt = 1'b1;
            end
        end
    end

    assign w_wr_hs = w_c0_wr_gnt | w_c1_wr_gnt;
    assign w_rd_hs = w_c0_rd_gnt | w_c1_rd_gnt;

    // Registered RAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_last     <= 1'b1;
            r_ram_wr_en   <= 1'b0;
            r_ram_wr_addr <= '0;
            r_ram_wr_data <= '0;
        end else begin
            r_ram_wr_en <= w_wr_hs;
            if (w_wr_hs) begin
                r_wr_last     <= w_c1_wr_gnt;
                r_ram_wr_addr <= w_c1_wr_gnt ? c1_wr_addr : c0_wr_addr;
                r_ram_wr_data <= w_c1_wr_gnt ? c1_wr_data : c0_wr_data;
            end
        end
    end

    // Same-cycle write and read to one address: the RAM returns old data, so bypass it.
    assign w_coll = r_vld[0] & r_ram_wr_en & (r_ram_wr_addr == r_ram_rd_addr);

    // Registered RAM read address and return pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_last     <= 1'b1;
            r_ram_rd_addr <= '0;
            r_vld         <= '0;
            r_id          <= '0;
            r_coll        <= '0;
            for (int i = 1; i <= int'(LAT); i++) begin
                r_fwd[i] <= '0;
            end
        end else begin
            if (w_rd_hs) begin
                r_rd_last     <= w_c1_rd_gnt;
                r_ram_rd_addr <= w_c1_rd_gnt ? c1_rd_addr : c0_rd_addr;
            end
            r_vld[0]  <= w_rd_hs;
            r_id[0]   <= w_c1_rd_gnt;
            r_vld[1]  <= r_vld[0];
            r_id[1]   <= r_id[0];
            r_coll[1] <= w_coll;
            r_fwd[1]  <= r_ram_wr_data;
            for (int i = 2; i <= int'(LAT); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_id[i]   <= r_id[i-1];
                r_coll[i] <= r_coll[i-1];
                r_fwd[i]  <= r_fwd[i-1];
            end
        end
    end

    // Return stage steering
    assign w_ret_vld  = r_vld[LAT] & ~rst;
    assign w_ret_data = r_coll[LAT] ? r_fwd[LAT] : ram_rd_data;

    assign c0_wr_gnt   = w_c0_wr_gnt;
    assign c1_wr_gnt   = w_c1_wr_gnt;
    assign c0_rd_gnt   = w_c0_rd_gnt;
    assign c1_rd_gnt   = w_c1_rd_gnt;
    assign c0_rd_valid = w_ret_vld & ~r_id[LAT];
    assign c1_rd_valid = w_ret_vld &  r_id[LAT];
    assign c0_rd_data  = c0_rd_valid ? w_ret_data : '0;
    assign c1_rd_data  = c1_rd_valid ? w_ret_data : '0;

    assign ram_wr_en   = r_ram_wr_en;
    assign ram_wr_addr = r_ram_wr_addr;
    assign ram_wr_data = r_ram_wr_data;
    assign ram_rd_addr = r_ram_rd_addr;

endmodule

// File: tb/tb_drm_port_arbiter.sv
// Directed bench for drm_port_arbiter: one instance per read latency (1 and 2), both
// driven by the same client stimulus, each backed by a behavioural read-first RAM.
module tb_drm_port_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          c0_wr_req, c1_wr_req, c0_rd_req, c1_rd_req;
    logic [AW-1:0] c0_wr_addr, c1_wr_addr, c0_rd_addr, c1_rd_addr;
    logic [DW-1:0] c0_wr_data, c1_wr_data;

    logic          o1_c0_wr_gnt, o1_c1_wr_gnt, o1_c0_rd_gnt, o1_c1_rd_gnt;
    logic          o1_c0_rd_valid, o1_c1_rd_valid;
    logic [DW-1:0] o1_c0_rd_data, o1_c1_rd_data;
    logic          o1_ram_wr_en;
    logic [AW-1:0] o1_ram_wr_addr, o1_ram_rd_addr;
    logic [DW-1:0] o1_ram_wr_data, o1_ram_rd_data;

    logic          o2_c0_wr_gnt, o2_c1_wr_gnt, o2_c0_rd_gnt, o2_c1_rd_gnt;
    logic          o2_c0_rd_valid, o2_c1_rd_valid;
    logic [DW-1:0] o2_c0_rd_data, o2_c1_rd_data;
    logic          o2_ram_wr_en;
    logic [AW-1:0] o2_ram_wr_addr, o2_ram_rd_addr;
    logic [DW-1:0] o2_ram_wr_data, o2_ram_rd_data;

    drm_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_data(c0_wr_data), .c0_wr_gnt(o1_c0_wr_gnt),
        .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data), .c1_wr_gnt(o1_c1_wr_gnt),
        .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_gnt(o1_c0_rd_gnt),
        .c0_rd_valid(o1_c0_rd_valid), .c0_rd_data(o1_c0_rd_data),
        .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_gnt(o1_c1_rd_gnt),
        .c1_rd_valid(o1_c1_rd_valid), .c1_rd_data(o1_c1_rd_data),
        .ram_wr_en(o1_ram_wr_en), .ram_wr_addr(o1_ram_wr_addr), .ram_wr_data(o1_ram_wr_data),
        .ram_rd_addr(o1_ram_rd_addr), .ram_rd_data(o1_ram_rd_data)
    );

    drm_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_data(c0_wr_data), .c0_wr_gnt(o2_c0_wr_gnt),
        .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data), .c1_wr_gnt(o2_c1_wr_gnt),
        .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_gnt(o2_c0_rd_gnt),
        .c0_rd_valid(o2_c0_rd_valid), .c0_rd_data(o2_c0_rd_data),
        .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_gnt(o2_c1_rd_gnt),
        .c1_rd_valid(o2_c1_rd_valid), .c1_rd_data(o2_c1_rd_data),
        .ram_wr_en(o2_ram_wr_en), .ram_wr_addr(o2_ram_wr_addr), .ram_wr_data(o2_ram_wr_data),
        .ram_rd_addr(o2_ram_rd_addr), .ram_rd_data(o2_ram_rd_data)
    );

    // Read-first SDP RAM models; the second one has an output register.
    logic [DW-1:0] mem1 [0:1023];
    logic [DW-1:0] mem2 [0:1023];
    logic [DW-1:0] ram2_q;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (o1_ram_wr_en) mem1[o1_ram_wr_addr] <= o1_ram_wr_data;
        o1_ram_rd_data <= mem1[o1_ram_rd_addr];
        if (o2_ram_wr_en) mem2[o2_ram_wr_addr] <= o2_ram_wr_data;
        ram2_q         <= mem2[o2_ram_rd_addr];
        o2_ram_rd_data <= ram2_q;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        c0_wr_req = 1'b0; c1_wr_req = 1'b0; c0_rd_req = 1'b0; c1_rd_req = 1'b0;
        c0_wr_addr = 10'h2AA; c1_wr_addr = 10'h155; c0_rd_addr = 10'h0F0; c1_rd_addr = 10'h30F;
        c0_wr_data = 32'hBAD0BAD0; c1_wr_data = 32'hBAD1BAD1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Scoreboard for the long c1 read sweep
    logic sb_on = 1'b0;
    int   q1_addr[$], q1_cyc[$], q2_addr[$], q2_cyc[$];
    int   n_ret1 = 0, n_ret2 = 0;

    always @(negedge clk) begin
        if (sb_on) begin
            if (c1_rd_req && o1_c1_rd_gnt) begin
                q1_addr.push_back(int'(c1_rd_addr)); q1_cyc.push_back(cyc);
                q2_addr.push_back(int'(c1_rd_addr)); q2_cyc.push_back(cyc);
            end
            if (o1_c1_rd_valid) begin
                n_ret1++;
                if (q1_addr.size() == 0) check("sweep1_unexpected", 64'd1, 64'd0);
                else check("sweep1_data_lat", {o1_c1_rd_data, 32'(cyc - q1_cyc.pop_front())},
                           {~32'(q1_addr.pop_front()), 32'd2});
            end
            if (o2_c1_rd_valid) begin
                n_ret2++;
                if (q2_addr.size() == 0) check("sweep2_unexpected", 64'd1, 64'd0);
                else check("sweep2_data_lat", {o2_c1_rd_data, 32'(cyc - q2_cyc.pop_front())},
                           {~32'(q2_addr.pop_front()), 32'd3});
            end
            if (o1_c0_rd_valid || o2_c0_rd_valid) check("sweep_c0_valid", 64'd1, 64'd0);
        end
    end

    int n_g0, n_g1;

    initial begin
        // Reset with requests present: nothing granted, everything idle
        rst = 1'b1;
        idle();
        c0_wr_req = 1'b1; c1_rd_req = 1'b1;
        nxt();
        mid();
        check("rst_wr_gnt", {o1_c0_wr_gnt, o1_c1_wr_gnt, o2_c0_wr_gnt, o2_c1_wr_gnt}, 4'b0);
        check("rst_rd_gnt", {o1_c0_rd_gnt, o1_c1_rd_gnt, o2_c0_rd_gnt, o2_c1_rd_gnt}, 4'b0);
        check("rst_wr_en", {o1_ram_wr_en, o2_ram_wr_en}, 2'b0);
        check("rst_rd_valid", {o1_c0_rd_valid, o1_c1_rd_valid, o2_c0_rd_valid, o2_c1_rd_valid}, 4'b0);
        check("rst_rd_addr", {o1_ram_rd_addr, o2_ram_rd_addr}, 20'h0);
        check("rst_rd_data", {o1_c0_rd_data, o1_c1_rd_data}, 64'h0);
        nxt();

        // Single write from c0, granted in the first cycle out of reset
        rst = 1'b0;
        idle();
        c0_wr_req = 1'b1; c0_wr_addr = 10'h005; c0_wr_data = 32'hDEADBEEF;
        mid();
        check("wr1_gnt", {o1_c0_wr_gnt, o1_c1_wr_gnt, o2_c0_wr_gnt}, 3'b101);
        nxt();
        idle();
        mid();
        check("wr1_ram_en", {o1_ram_wr_en, o2_ram_wr_en}, 2'b11);
        check("wr1_ram_addr", o1_ram_wr_addr, 10'h005);
        check("wr1_ram_data", o1_ram_wr_data, 32'hDEADBEEF);
        nxt();
        mid();
        check("wr1_ram_en_off", o1_ram_wr_en, 1'b0);

        // Both clients write continuously: strict alternation starting at c0
        nxt();
        reset_dut();
        n_g0 = 0; n_g1 = 0;
        for (int i = 0; i < 6; i++) begin
            c0_wr_req = 1'b1; c0_wr_addr = 10'(32'h100 + i); c0_wr_data = 32'hC0000000 + i;
            c1_wr_req = 1'b1; c1_wr_addr = 10'(32'h200 + i); c1_wr_data = 32'hC1000000 + i;
            mid();
            check("rr_wr_gnt", {o1_c0_wr_gnt, o1_c1_wr_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0)
                check("rr_wr_addr", o1_ram_wr_addr, (i % 2 == 1) ? 10'(32'h100 + i - 1) : 10'(32'h200 + i - 1));
            n_g0 += int'(o1_c0_wr_gnt);
            n_g1 += int'(o1_c1_wr_gnt);
            nxt();
        end
        idle();
        mid();
        check("rr_wr_last", {o1_ram_wr_data, 22'h0, o1_ram_wr_addr}, {32'hC1000005, 32'h205});
        check("rr_wr_counts", {32'(n_g0), 32'(n_g1)}, {32'd3, 32'd3});

        // c1 reads 0x3FF holding 0x12345678
        nxt();
        c0_wr_req = 1'b1; c0_wr_addr = 10'h3FF; c0_wr_data = 32'h12345678;
        nxt();
        idle();
        nxt();
        nxt();
        c1_rd_req = 1'b1; c1_rd_addr = 10'h3FF;
        mid();
        check("rd1_gnt", {o1_c0_rd_gnt, o1_c1_rd_gnt}, 2'b01);
        nxt();
        idle();
        mid();
        check("rd1_ram_addr", o1_ram_rd_addr, 10'h3FF);
        check("rd1_early", o1_c1_rd_valid, 1'b0);
        nxt();
        mid();
        check("rd1_l1_ret", {o1_c1_rd_valid, o1_c0_rd_valid, o1_c1_rd_data}, {2'b10, 32'h12345678});
        check("rd1_l2_early", o2_c1_rd_valid, 1'b0);
        check("rd1_addr_hold", o1_ram_rd_addr, 10'h3FF);
        nxt();
        mid();
        check("rd1_l2_ret", {o2_c1_rd_valid, o2_c0_rd_valid, o2_c1_rd_data}, {2'b10, 32'h12345678});
        check("rd1_l1_once", o1_c1_rd_valid, 1'b0);

        // Same-cycle write and read of 0x010: forwarded write data
        nxt();
        c0_wr_req = 1'b1; c0_wr_addr = 10'h010; c0_wr_data = 32'hA5A5A5A5;
        c1_rd_req = 1'b1; c1_rd_addr = 10'h010;
        mid();
        check("fwd_gnts", {o1_c0_wr_gnt, o1_c1_rd_gnt}, 2'b11);
        nxt();
        idle();
        nxt();
        mid();
        check("fwd_l1", {o1_c1_rd_valid, o1_c1_rd_data}, {1'b1, 32'hA5A5A5A5});
        nxt();
        mid();
        check("fwd_l2", {o2_c1_rd_valid, o2_c1_rd_data}, {1'b1, 32'hA5A5A5A5});

        // Read one cycle after a write to the same address sees new RAM data
        nxt();
        c0_wr_req = 1'b1; c0_wr_addr = 10'h020; c0_wr_data = 32'h11111111;
        nxt();
        idle();
        c0_rd_req = 1'b1; c0_rd_addr = 10'h020;
        mid();
        check("raw_gnt", o1_c0_rd_gnt, 1'b1);
        nxt();
        idle();
        nxt();
        mid();
        check("raw_l1", {o1_c0_rd_valid, o1_c0_rd_data}, {1'b1, 32'h11111111});
        nxt();
        mid();
        check("raw_l2", {o2_c0_rd_valid, o2_c0_rd_data}, {1'b1, 32'h11111111});

        // Both clients read: c0 went last, so c1 first; returns steered per client
        nxt();
        c0_rd_req = 1'b1; c0_rd_addr = 10'h005;
        c1_rd_req = 1'b1; c1_rd_addr = 10'h010;
        mid();
        check("rr_rd_a", {o1_c0_rd_gnt, o1_c1_rd_gnt}, 2'b01);
        nxt();
        c1_rd_req = 1'b0;
        mid();
        check("rr_rd_b", {o1_c0_rd_gnt, o1_c1_rd_gnt}, 2'b10);
        nxt();
        idle();
        mid();
        check("rr_ret1_l1", {o1_c1_rd_valid, o1_c0_rd_valid, o1_c1_rd_data}, {2'b10, 32'hA5A5A5A5});
        nxt();
        mid();
        check("rr_ret2_l1", {o1_c0_rd_valid, o1_c1_rd_valid, o1_c0_rd_data}, {2'b10, 32'hDEADBEEF});
        check("rr_ret1_l2", {o2_c1_rd_valid, o2_c1_rd_data}, {1'b1, 32'hA5A5A5A5});
        nxt();
        mid();
        check("rr_ret2_l2", {o2_c0_rd_valid, o2_c1_rd_valid, o2_c0_rd_data}, {2'b10, 32'hDEADBEEF});

        // One-cycle reset with two reads in flight: discarded, pointers back to c0
        nxt();
        c1_rd_req = 1'b1; c1_rd_addr = 10'h3FF;
        nxt();
        idle();
        c0_rd_req = 1'b1; c0_rd_addr = 10'h010;
        nxt();
        rst = 1'b1;
        idle();
        c0_wr_req = 1'b1; c1_rd_req = 1'b1;
        mid();
        check("inrst_gnt", {o1_c0_wr_gnt, o1_c1_rd_gnt, o2_c0_wr_gnt, o2_c1_rd_gnt}, 4'b0);
        check("inrst_valid", {o1_c0_rd_valid, o1_c1_rd_valid}, 2'b0);
        nxt();
        rst = 1'b0;
        idle();
        mid();
        check("postrst_valid_a", {o1_c0_rd_valid, o1_c1_rd_valid, o2_c0_rd_valid, o2_c1_rd_valid}, 4'b0);
        nxt();
        c0_wr_req = 1'b1; c0_wr_addr = 10'h030; c0_wr_data = 32'h0;
        c1_wr_req = 1'b1; c1_wr_addr = 10'h031; c1_wr_data = 32'h0;
        c0_rd_req = 1'b1; c1_rd_req = 1'b1;
        mid();
        check("postrst_valid_b", {o1_c0_rd_valid, o1_c1_rd_valid, o2_c0_rd_valid, o2_c1_rd_valid}, 4'b0);
        check("postrst_ptr", {o1_c0_wr_gnt, o1_c1_wr_gnt, o1_c0_rd_gnt, o1_c1_rd_gnt}, 4'b1010);
        check("postrst_ptr_l2", {o2_c0_wr_gnt, o2_c0_rd_gnt}, 2'b11);
        nxt();
        idle();
        for (int i = 0; i < 5; i++) nxt();

        // Fill the RAM from c0 with ~addr, then stream 1024 reads from c1
        for (int a = 0; a < 1024; a++) begin
            c0_wr_req = 1'b1; c0_wr_addr = 10'(a); c0_wr_data = ~32'(a);
            nxt();
        end
        idle();
        nxt();
        sb_on = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            c1_rd_req = 1'b1; c1_rd_addr = 10'(a);
            nxt();
        end
        idle();
        for (int i = 0; i < 6; i++) nxt();
        sb_on = 1'b0;
        check("sweep_returns", {32'(n_ret1), 32'(n_ret2)}, {32'd1024, 32'd1024});
        check("sweep_drained", {32'(q1_addr.size()), 32'(q2_addr.size())}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
